// File: rtl/uart_tx_arb_pkg.sv
// Shared constants, FSM state encoding and a one-hot decode helper for the
// four-requester UART transmit arbiter.
package uart_tx_arb_pkg;

  localparam int N_REQ   = 4;
  localparam int IDX_W   = 2;
  localparam int BYTE_W  = 8;
  localparam int BURST_W = 6;
  localparam int TIMEOUT = 16;
  localparam int TMO_W   = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first requester at or after
// last_owner+1 (wrapping), returned one-hot together with a found flag.
module rr_priority_picker
  import uart_tx_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_owner_i,
  output logic [N_REQ-1:0] pick_o,
  output logic             valid_o
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    pick_o  = '0;
    valid_o = 1'b0;
    cand    = '0;
    // Offset N_REQ wraps to the last owner itself, so it is tried last.
    for (int k = 1; k <= N_REQ; k++) begin
      cand = last_owner_i + IDX_W'(k);
      if (!valid_o && req_i[cand]) begin
        pick_o[cand] = 1'b1;
        valid_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates four byte streams onto one transmitter FIFO write port, holding
// a grant per message with burst-limit and idle-timeout release.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
(
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic [N_REQ-1:0]       req_valid_i,
  input  logic [N_REQ*BYTE_W-1:0] req_data_i,
  input  logic [N_REQ-1:0]       req_last_i,
  output logic [N_REQ-1:0]       req_ready_o,
  input  logic [BURST_W-1:0]     max_burst_i,
  output logic [BYTE_W-1:0]      data_o,
  output logic                   data_write_o,
  input  logic                   data_buffer_full_i,
  output logic [N_REQ-1:0]       grant_o,
  output logic                   busy_o
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_owner_q, last_owner_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [TMO_W-1:0]   idle_q, idle_d;

  logic [N_REQ-1:0]   pick;
  logic               pick_valid;
  logic               transfer;
  logic               owner_valid;
  logic               release_grant;
  logic [BURST_W-1:0] burst_inc;
  logic [BYTE_W-1:0]  owner_byte;

  rr_priority_picker u_picker (
    .req_i        (req_valid_i),
    .last_owner_i (last_owner_q),
    .pick_o       (pick),
    .valid_o      (pick_valid)
  );

  assign owner_byte = req_data_i[{owner_q, 3'b000} +: BYTE_W];

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_owner_d  = last_owner_q;
    burst_d       = burst_q;
    idle_d        = idle_q;
    transfer      = 1'b0;
    owner_valid   = 1'b0;
    release_grant = 1'b0;
    burst_inc     = burst_q + BURST_W'(1);

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          owner_d = onehot_to_idx(pick);
          burst_d = '0;
          idle_d  = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        owner_valid = req_valid_i[owner_q];
        transfer    = owner_valid && !data_buffer_full_i;

        // A stalled-but-valid owner is not idle; only an absent byte counts.
        if (owner_valid) begin
          idle_d = '0;
        end else if (idle_q == TMO_W'(TIMEOUT - 1)) begin
          release_grant = 1'b1;
        end else begin
          idle_d = idle_q + TMO_W'(1);
        end

        if (transfer) begin
          burst_d = burst_inc;
          if (req_last_i[owner_q] ||
              ((max_burst_i != '0) && (burst_inc == max_burst_i))) begin
            release_grant = 1'b1;
          end
        end

        if (release_grant) begin
          state_d      = IDLE;
          last_owner_d = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_owner_q <= IDX_W'(N_REQ - 1);
      burst_q      <= '0;
      idle_q       <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      burst_q      <= burst_d;
      idle_q       <= idle_d;
    end
  end

  assign busy_o       = (state_q == STREAM);
  assign data_write_o = transfer;
  assign data_o       = transfer ? owner_byte : '0;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_port
      assign grant_o[gi]     = busy_o   && (owner_q == IDX_W'(gi));
      assign req_ready_o[gi] = transfer && (owner_q == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised bench for uart_tx_arbiter: per-requester byte queues feed the DUT
// and a rule-level model predicts grant/ready/write/data every cycle.
module tb_uart_tx_arbiter;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic [3:0]  req_valid_i;
  logic [31:0] req_data_i;
  logic [3:0]  req_last_i;
  logic [3:0]  req_ready_o;
  logic [5:0]  max_burst_i;
  logic [7:0]  data_o;
  logic        data_write_o;
  logic        data_buffer_full_i;
  logic [3:0]  grant_o;
  logic        busy_o;

  uart_tx_arbiter dut (
    .clock_i            (clock_i),
    .reset_i            (reset_i),
    .req_valid_i        (req_valid_i),
    .req_data_i         (req_data_i),
    .req_last_i         (req_last_i),
    .req_ready_o        (req_ready_o),
    .max_burst_i        (max_burst_i),
    .data_o             (data_o),
    .data_write_o       (data_write_o),
    .data_buffer_full_i (data_buffer_full_i),
    .grant_o            (grant_o),
    .busy_o             (busy_o)
  );

  always #5 clock_i = ~clock_i;

  int tests_run    = 0;
  int tests_failed = 0;

  // Source side: each entry is {last, byte}; front entry is what is offered.
  logic [8:0] src_q [4][$];
  logic [3:0] gate_mask;
  int         gap_pct;
  int         full_pct;
  logic       full_force;
  int         pushed_bytes;

  // Reference model: who owns the port and the release rules, in plain terms.
  bit         m_busy;
  logic [1:0] m_owner;
  logic [1:0] m_last;
  int         m_count;
  int         m_quiet;

  int         wlog[$];
  logic [3:0] obs_grant;
  logic       obs_write;

  function automatic int grant_idx(input logic [3:0] g);
    int r;
    r = -1;
    for (int i = 0; i < 4; i++) if (g[i]) r = i;
    return r;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 2'd0; m_last = 2'd3; m_count = 0; m_quiet = 0;
  endtask

  task automatic step();
    logic [3:0]  v, lst, e_grant, e_ready;
    logic [31:0] d;
    logic        full, e_write, e_busy;
    logic [7:0]  e_data;
    bit          xfer, done, found;
    logic [1:0]  xo, cand;
    for (int k = 0; k < 4; k++) begin
      v[k] = (src_q[k].size() > 0) && gate_mask[k] && (int'($urandom_range(99)) >= gap_pct);
      if (src_q[k].size() > 0) begin
        d[8*k +: 8] = src_q[k][0][7:0];
        lst[k]      = src_q[k][0][8];
      end else begin
        d[8*k +: 8] = 8'($urandom);
        lst[k]      = 1'($urandom);
      end
    end
    full = full_force || (int'($urandom_range(99)) < full_pct);
    req_valid_i = v; req_data_i = d; req_last_i = lst; data_buffer_full_i = full;

    @(negedge clock_i);
    e_grant = 4'b0; e_ready = 4'b0; e_write = 1'b0; e_busy = 1'b0; e_data = 8'h00;
    xfer = 0; xo = m_owner;
    if (m_busy) begin
      e_busy = 1'b1;
      e_grant[m_owner] = 1'b1;
      xfer = v[m_owner] && !full;
      if (xfer) begin
        e_ready[m_owner] = 1'b1;
        e_write = 1'b1;
        e_data = src_q[m_owner][0][7:0];
      end
    end
    tests_run++;
    if (grant_o !== e_grant) begin
      tests_failed++; $display("FAIL grant @%0t: got %b want %b", $time, grant_o, e_grant);
    end
    tests_run++;
    if (req_ready_o !== e_ready) begin
      tests_failed++; $display("FAIL ready @%0t: got %b want %b", $time, req_ready_o, e_ready);
    end
    tests_run++;
    if (data_write_o !== e_write) begin
      tests_failed++; $display("FAIL write @%0t: got %b want %b", $time, data_write_o, e_write);
    end
    tests_run++;
    if (data_o !== e_data) begin
      tests_failed++; $display("FAIL data @%0t: got %h want %h", $time, data_o, e_data);
    end
    tests_run++;
    if (busy_o !== e_busy) begin
      tests_failed++; $display("FAIL busy @%0t: got %b want %b", $time, busy_o, e_busy);
    end
    obs_grant = grant_o;
    obs_write = data_write_o;
    if (data_write_o === 1'b1) wlog.push_back(grant_idx(grant_o) * 256 + int'(data_o));

    @(posedge clock_i);
    if (reset_i) begin
      model_reset();
    end else if (!m_busy) begin
      found = 0;
      for (int s = 1; s <= 4; s++) begin
        cand = m_last + 2'(s);
        if (!found && v[cand]) begin
          found = 1; m_busy = 1; m_owner = cand; m_count = 0; m_quiet = 0;
        end
      end
    end else begin
      done = 0;
      if (xfer) begin
        m_count = (m_count + 1) % 64;
        if (lst[m_owner] || (max_burst_i != 0 && m_count == int'(max_burst_i))) done = 1;
      end
      if (v[m_owner]) m_quiet = 0;
      else begin
        m_quiet++;
        if (m_quiet == 16) done = 1;
      end
      if (done) begin m_last = m_owner; m_busy = 0; end
    end
    if (xfer) void'(src_q[xo].pop_front());
    #1;
  endtask

  task automatic push_msg(input int k, input int len, input bit with_last);
    for (int i = 0; i < len; i++) begin
      src_q[k].push_back({(with_last && i == len - 1), 8'($urandom)});
      pushed_bytes++;
    end
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while ((src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size() > 0 || m_busy)
           && n < bound) begin
      step();
      n++;
    end
    tests_run++;
    if (n >= bound) begin
      tests_failed++; $display("FAIL drain: still busy after %0d cycles, limit %0d", n, bound);
    end
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    for (int k = 0; k < 4; k++) src_q[k].delete();
    wlog.delete();
    gate_mask = 4'hF; gap_pct = 0; full_pct = 0; full_force = 1'b0;
    max_burst_i = 6'd0; pushed_bytes = 0;
    step();
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    reset_i = 1'b1;
    for (int k = 0; k < 4; k++) push_msg(k, 1, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (obs_grant !== 4'b0 || obs_write !== 1'b0) begin
        tests_failed++; $display("FAIL reset_hold: grant %b write %b want 0000 0", obs_grant, obs_write);
      end
    end
    reset_i = 1'b0;
    step();
    step();
    tests_run++;
    if (obs_grant !== 4'b0001) begin
      tests_failed++; $display("FAIL reset_first_grant: got %b want 0001", obs_grant);
    end
    drain(200);
  endtask

  task automatic test_single_message();
    do_reset();
    src_q[0].push_back({1'b0, 8'h41});
    src_q[0].push_back({1'b0, 8'h42});
    src_q[0].push_back({1'b1, 8'h43});
    step();
    tests_run++;
    if (obs_grant !== 4'b0000) begin
      tests_failed++; $display("FAIL single_idle: got %b want 0000", obs_grant);
    end
    step();
    tests_run++;
    if (obs_grant !== 4'b0001) begin
      tests_failed++; $display("FAIL single_grant: got %b want 0001", obs_grant);
    end
    drain(100);
    tests_run++;
    if (wlog.size() != 3 || wlog[0] != 'h41 || wlog[1] != 'h42 || wlog[2] != 'h43) begin
      tests_failed++; $display("FAIL single_bytes: got %0d writes, want 3 (41 42 43)", wlog.size());
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int r = 0; r < 2; r++) for (int k = 0; k < 4; k++) push_msg(k, 1, 1);
    drain(200);
    tests_run++;
    if (wlog.size() != 8) begin
      tests_failed++; $display("FAIL rr_count: got %0d writes want 8", wlog.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        tests_run++;
        if (wlog[i] / 256 != i % 4) begin
          tests_failed++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, wlog[i] / 256, i % 4);
        end
      end
    end
  endtask

  task automatic test_max_burst();
    int exp_o [12] = '{2, 2, 2, 2, 1, 1, 2, 2, 2, 2, 2, 2};
    do_reset();
    max_burst_i = 6'd4;
    push_msg(2, 10, 0);
    step();
    step();
    push_msg(1, 2, 1);
    drain(400);
    tests_run++;
    if (wlog.size() != 12) begin
      tests_failed++; $display("FAIL burst_count: got %0d writes want 12", wlog.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        tests_run++;
        if (wlog[i] / 256 != exp_o[i]) begin
          tests_failed++; $display("FAIL burst_owner[%0d]: got %0d want %0d", i, wlog[i] / 256, exp_o[i]);
        end
      end
    end
  endtask

  task automatic test_full_stall();
    int writes, held;
    do_reset();
    push_msg(0, 5, 1);
    step(); step(); step();
    full_force = 1'b1;
    writes = 0; held = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      writes += int'(obs_write);
      if (obs_grant === 4'b0001) held++;
    end
    full_force = 1'b0;
    tests_run++;
    if (writes != 0 || held != 20) begin
      tests_failed++; $display("FAIL full_stall: writes %0d held %0d want 0 and 20", writes, held);
    end
    drain(100);
    tests_run++;
    if (wlog.size() != 5) begin
      tests_failed++; $display("FAIL full_resume: got %0d writes want 5", wlog.size());
    end
  endtask

  task automatic test_timeout();
    int held;
    do_reset();
    push_msg(1, 3, 1);
    step(); step();
    gate_mask[1] = 1'b0;
    for (int i = 0; i < 15; i++) step();
    gate_mask[1] = 1'b1;
    step();
    tests_run++;
    if (obs_grant !== 4'b0010 || obs_write !== 1'b1) begin
      tests_failed++; $display("FAIL timeout_15_kept: grant %b write %b want 0010 1", obs_grant, obs_write);
    end
    drain(100);
    push_msg(1, 2, 1);
    step(); step();
    gate_mask[1] = 1'b0;
    held = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (obs_grant === 4'b0010) held++;
    end
    step();
    tests_run++;
    if (held != 16 || obs_grant !== 4'b0000) begin
      tests_failed++; $display("FAIL timeout_16_release: held %0d grant %b want 16 0000", held, obs_grant);
    end
    gate_mask[1] = 1'b1;
    drain(100);
    tests_run++;
    if (wlog.size() != 5) begin
      tests_failed++; $display("FAIL timeout_bytes: got %0d writes want 5", wlog.size());
    end
  endtask

  task automatic test_reset_mid_message();
    do_reset();
    push_msg(1, 5, 1);
    step(); step();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    push_msg(0, 1, 1);
    step();
    tests_run++;
    if (obs_grant !== 4'b0000 || obs_write !== 1'b0) begin
      tests_failed++; $display("FAIL reset_mid_idle: grant %b write %b want 0000 0", obs_grant, obs_write);
    end
    step();
    tests_run++;
    if (obs_grant !== 4'b0001) begin
      tests_failed++; $display("FAIL reset_mid_regrant: got %b want 0001", obs_grant);
    end
    drain(200);
  endtask

  task automatic test_random();
    do_reset();
    gap_pct = 20; full_pct = 15;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(9) == 0) begin
        int k;
        k = int'($urandom_range(3));
        if (src_q[k].size() < 12) push_msg(k, int'($urandom_range(8, 1)), $urandom_range(9) != 0);
      end
      if (c % 97 == 0) max_burst_i = ($urandom_range(3) == 0) ? 6'd0 : 6'($urandom_range(6, 1));
      step();
    end
    gap_pct = 0; full_pct = 0;
    drain(3000);
    tests_run++;
    if (wlog.size() != pushed_bytes) begin
      tests_failed++; $display("FAIL random_total: got %0d writes want %0d", wlog.size(), pushed_bytes);
    end
  endtask

  initial begin
    reset_i = 1'b1; req_valid_i = 4'b0; req_data_i = 32'b0; req_last_i = 4'b0;
    max_burst_i = 6'd0; data_buffer_full_i = 1'b0;
    gate_mask = 4'hF; gap_pct = 0; full_pct = 0; full_force = 1'b0; pushed_bytes = 0;
    model_reset();
    @(posedge clock_i);
    #1;
    test_reset();
    test_single_message();
    test_round_robin();
    test_max_burst();
    test_full_stall();
    test_timeout();
    test_reset_mid_message();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
